nv_ram_rwsthp_fifo_ctrl: RTL

//  FIFO sequencer that owns the ports of an 80x72 two-port RAM (rwsthp: registered read

---
 rtl/nv_ram_rwsthp_fifo_ctrl_if.sv | 66 ++++++
 rtl/nv_ram_rwsthp_fifo_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/nv_ram_rwsthp_fifo_ctrl_if.sv
// ----------------------------------------------------------------------------
// nv_ram_rwsthp_fifo_ctrl_if
// Bundles the signals around the FIFO sequencer:
// - its valid/ready write side and read side,
// - the write, read and bypass ports of the rwsthp RAM,
// - the occupancy count.
//
// Modports:
//   slave  - the sequencer. It drives the handshake outputs, the RAM controls
//            and fifo_count.
//   master - the environment. It drives the producer/consumer inputs and the
//            RAM read data.
//
// Signals:
//   wr_pvld/wr_prdy/wr_pd   write handshake and data
//   rd_pvld/rd_prdy/rd_pd   read handshake and data
//   ram_wa/ram_we/ram_di    RAM write port
//   ram_ra/ram_re/ram_ore   RAM read address, read enable, output-reg enable
//   ram_byp_sel/ram_dbyp    RAM bypass select and data
//   ram_dout                RAM registered output
//   fifo_count              total words held
// ----------------------------------------------------------------------------
interface nv_ram_rwsthp_fifo_ctrl_if #(
  parameter int unsigned AW = 7,
  parameter int unsigned DW = 72
);
  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;

  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;

  logic [AW-1:0] ram_wa;
  logic          ram_we;
  logic [DW-1:0] ram_di;

  logic [AW-1:0] ram_ra;
  logic          ram_re;
  logic          ram_ore;

  logic          ram_byp_sel;
  logic [DW-1:0] ram_dbyp;
  logic [DW-1:0] ram_dout;

  logic [6:0]    fifo_count;

  modport slave (
    input  wr_pvld, wr_pd, rd_prdy, ram_dout,
    output wr_prdy, rd_pvld, rd_pd,
    output ram_wa, ram_we, ram_di,
    output ram_ra, ram_re, ram_ore,
    output ram_byp_sel, ram_dbyp,
    output fifo_count
  );

  modport master (
    output wr_pvld, wr_pd, rd_prdy, ram_dout,
    input  wr_prdy, rd_pvld, rd_pd,
    input  ram_wa, ram_we, ram_di,
    input  ram_ra, ram_re, ram_ore,
    input  ram_byp_sel, ram_dbyp,
    input  fifo_count
  );
endinterface

// File: rtl/nv_ram_rwsthp_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// nv_ram_rwsthp_fifo_ctrl
// FIFO sequencer that owns the ports of a DEPTH x DW two-port rwsthp RAM.
// The RAM has a registered read address, an output-register enable and a
// bypass mux.
//
// Read path:
// - The 2-cycle RAM read latency is hidden by a read pipeline that keeps at
//   most two words past the RAM: one in flight, one on ram_dout.
// - A 1-entry skid register absorbs the word on ram_dout when the consumer
//   stalls.
// - With BYPASS_EN=1, a write into an otherwise drained FIFO skips the RAM
//   array. It goes straight through the bypass mux into the output register.
//
// Ports:
//   nvdla_core_clk   clock, all state on rising edge
//   nvdla_core_rstn  synchronous active-low reset
//   bus (slave)      write/read handshakes, RAM ports, fifo_count
// ----------------------------------------------------------------------------
module nv_ram_rwsthp_fifo_ctrl #(
  parameter int unsigned DEPTH     = 80,
  parameter int unsigned AW        = 7,
  parameter int unsigned DW        = 72,
  parameter bit          BYPASS_EN = 1'b1
) (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rstn,
  nv_ram_rwsthp_fifo_ctrl_if.slave bus
);

  localparam int unsigned   CW       = 7;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // Architectural state
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] ram_cnt_q, ram_cnt_d;
  logic          s1_vld_q, s1_vld_d;
  logic          dout_vld_q, dout_vld_d;
  logic          skid_vld_q, skid_vld_d;
  logic [DW-1:0] skid_pd_q;

  // Per-cycle decisions
  logic          run_c;
  logic          wr_prdy_c;
  logic          rd_pvld_c;
  logic          push_c;
  logic          pop_c;
  logic [1:0]    occ_c;
  logic [1:0]    occ_left_c;
  logic          room_c;
  logic          byp_c;
  logic          we_c;
  logic          re_c;
  logic          ore_c;
  logic          skid_load_c;
  logic [CW-1:0] count_c;

  // Handshake, credit and RAM-control decisions from registered state
  always_comb begin
    run_c       = nvdla_core_rstn;
    occ_c       = 2'({1'b0, s1_vld_q}) + 2'({1'b0, dout_vld_q}) + 2'({1'b0, skid_vld_q});
    wr_prdy_c   = run_c & (ram_cnt_q < CNT_FULL);
    rd_pvld_c   = run_c & (skid_vld_q | dout_vld_q);
    push_c      = bus.wr_pvld & wr_prdy_c;
    pop_c       = rd_pvld_c & bus.rd_prdy;
    // Words past the RAM that remain after this cycle's pop; a new word may
    // only be started toward the output stage while fewer than two remain.
    occ_left_c  = occ_c - {1'b0, pop_c};
    room_c      = (occ_left_c < 2'd2);
    // Bypass only when nothing older sits in the array or in the read stage.
    byp_c       = BYPASS_EN & push_c & (ram_cnt_q == '0) & ~s1_vld_q & room_c;
    we_c        = push_c & ~byp_c;
    // ram_cnt only counts words written on earlier cycles, so a word is never
    // issued in its own push cycle.
    re_c        = run_c & (ram_cnt_q != '0) & room_c;
    ore_c       = run_c & (s1_vld_q | byp_c);
    // Output register is about to be overwritten while it still holds an
    // unconsumed word: move that word into the skid.
    skid_load_c = ore_c & dout_vld_q & ~(pop_c & ~skid_vld_q);
    count_c     = run_c ? (ram_cnt_q + CW'(occ_c)) : '0;
  end

  // Next-state for pointers, counter and read-pipeline flags
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    s1_vld_d   = re_c;
    dout_vld_d = ore_c | (dout_vld_q & ~(pop_c & ~skid_vld_q));
    skid_vld_d = skid_load_c | (skid_vld_q & ~pop_c);

    if (we_c) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : (wr_ptr_q + AW'(1));
    end
    if (re_c) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : (rd_ptr_q + AW'(1));
    end

    case ({we_c, re_c})
      2'b10:   ram_cnt_d = ram_cnt_q + CW'(1);
      2'b01:   ram_cnt_d = ram_cnt_q - CW'(1);
      default: ram_cnt_d = ram_cnt_q;
    endcase
  end

  // Control state register
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      s1_vld_q   <= 1'b0;
      dout_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      s1_vld_q   <= s1_vld_d;
      dout_vld_q <= dout_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  // Skid data register, qualified by skid_vld_q so no reset needed
  always_ff @(posedge nvdla_core_clk) begin
    if (skid_load_c) begin
      skid_pd_q <= bus.ram_dout;
    end
  end

  // Handshake outputs
  assign bus.wr_prdy     = wr_prdy_c;
  assign bus.rd_pvld     = rd_pvld_c;
  // The skid word is always older than the word on ram_dout.
  assign bus.rd_pd       = skid_vld_q ? skid_pd_q : bus.ram_dout;

  // RAM write port
  assign bus.ram_wa      = wr_ptr_q;
  assign bus.ram_we      = we_c;
  assign bus.ram_di      = bus.wr_pd;

  // RAM read and bypass controls
  assign bus.ram_ra      = rd_ptr_q;
  assign bus.ram_re      = re_c;
  assign bus.ram_ore     = ore_c;
  assign bus.ram_byp_sel = byp_c;
  assign bus.ram_dbyp    = bus.wr_pd;

  // Occupancy
  assign bus.fifo_count  = count_c;

endmodule
